// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential calculator ALU:
//                op-code constants and the control state encoding.
//  Contents    : OP_ADD / OP_SUB / OP_MUL / OP_DIV  (2-bit op codes)
//                state_t                           (IDLE, ITER, DONE)
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_unit
//  Description : One-bit-per-cycle engine shared by multiply (shift-add) and
//                divide (restoring shift-subtract). A single 2*WIDTH register
//                holds the partial product or the {remainder, quotient} pair.
//  Ports       : clk, rst    clock, synchronous active-low reset
//                start       load operands and clear the counter
//                is_div      with start: 1 = divide, 0 = multiply
//                step        perform one iteration this cycle
//                a, b        raw operands, sampled with start
//                last        counter has reached WIDTH-1 (final step)
//                acc         product, or {remainder, quotient}
//  Revision    : 1.0  initial release
// ============================================================================
module alu_iter_unit #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_div,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last,
   output logic [2*WIDTH-1:0] acc
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
   logic               div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      // Multiply: low half starts as the multiplier and drains out to the
      // right while the product grows in from the top; the carry of the
      // upper-half add becomes the new MSB after the shift.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Divide: shift the next dividend bit into the partial remainder and
      // try the subtraction; the MSB of the (WIDTH+1)-bit difference is the
      // borrow, which means "restore" and shift in a 0 quotient bit.
      rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
      rem_diff  = rem_shift - {1'b0, opnd_q};
      if (rem_diff[WIDTH]) begin
         div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      if (start) begin
         acc_d  = is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
         opnd_d = is_div ? b : a;
         div_d  = is_div;
         cnt_d  = '0;
      end else if (step) begin
         acc_d = div_q ? div_next : mul_next;
         // Counter saturates at WIDTH-1 rather than wrapping.
         if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
      end
   end

   assign last = (cnt_q == CNT_LAST);
   assign acc  = acc_q;

endmodule : alu_iter_unit
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle unsigned ALU. Add/sub (and divide by zero)
//                finish one cycle after accept; multiply/divide iterate one
//                bit per cycle in alu_iter_unit behind an en/busy/valid
//                handshake.
//  Ports       : clk, rst      clock, synchronous active-low reset
//                en            start request, taken only while busy=0
//                operation     0 add, 1 sub, 2 mul, 3 div
//                A, B          operands (dividend / divisor for div)
//                result        registered result, held until next valid
//                valid         one-cycle pulse when result updates
//                busy          iterative operation in progress
//                div_by_zero   set with valid for div by 0, cleared on accept
//  Revision    : 1.0  initial release
// ============================================================================
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         operation,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] result,
   output logic               valid,
   output logic               busy,
   output logic               div_by_zero
);

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               valid_q, valid_d;
   logic               dbz_q, dbz_d;

   logic               cur_dbz;
   logic               cur_is_iter;
   logic               new_is_iter;
   logic               busy_w;
   logic               accept;
   logic               start_iter;
   logic               iter_last;
   logic [2*WIDTH-1:0] iter_acc;

   // Handshake decode. busy stays high through the DONE cycle of an
   // iterative op so that the only accept slot is the valid cycle; for
   // single-cycle ops DONE is not busy, allowing one accept per cycle.
   always_comb begin
      cur_dbz     = (op_q == OP_DIV) && (b_q == '0);
      cur_is_iter = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
      new_is_iter = (operation == OP_MUL)
                 || ((operation == OP_DIV) && (B != '0));
      busy_w      = (state_q == ITER) || ((state_q == DONE) && cur_is_iter);
      accept      = en && !busy_w;
      start_iter  = accept && new_is_iter;
   end

   alu_iter_unit #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start_iter),
      .is_div (operation == OP_DIV),
      .step   (state_q == ITER),
      .a      (A),
      .b      (B),
      .last   (iter_last),
      .acc    (iter_acc)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = new_is_iter ? ITER : DONE;
            end
         end
         ITER: begin
            if (iter_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (accept) begin
               state_d = new_is_iter ? ITER : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture and completion. The DONE cycle is the one that
   // produces the result: the edge leaving DONE loads result and raises
   // valid for exactly one cycle.
   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      valid_d  = 1'b0;
      dbz_d    = dbz_q;

      if (accept) begin
         op_d = operation;
         a_d  = A;
         b_d  = B;
      end

      if (state_q == DONE) begin
         valid_d = 1'b1;
         dbz_d   = cur_dbz;
         case (op_q)
            OP_ADD:  result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            OP_SUB:  result_d = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
            OP_MUL:  result_d = iter_acc;
            default: result_d = cur_dbz ? {a_q, {WIDTH{1'b1}}} : iter_acc;
         endcase
      end else if (accept) begin
         // A completing op owns the flag in its valid cycle; otherwise a
         // fresh accept clears any stale divide-by-zero indication.
         dbz_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         dbz_q    <= dbz_d;
      end
   end

   assign result      = result_q;
   assign valid       = valid_q;
   assign busy        = busy_w;
   assign div_by_zero = dbz_q;

endmodule : seq_alu
`default_nettype wire
